// File: rtl/baud_tick_gen_if.sv
// Handshake bundle for the UART baud-rate generator:
// control/divisor inputs plus the registered tick outputs.
interface baud_tick_gen_if #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
);
  logic              en;
  logic              restart;
  logic              load;
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              os_tick;
  logic              bit_tick;
  logic              baud;
  logic              pend;

  modport master (
    output en, restart, load, div_int, div_frac,
    input  os_tick, bit_tick, baud, pend
  );

  modport slave (
    input  en, restart, load, div_int, div_frac,
    output os_tick, bit_tick, baud, pend
  );
endinterface

// File: rtl/baud_tick_gen.sv
// Fractional, runtime-programmable baud generator: oversample tick,
// bit tick and legacy low-then-high baud square wave.
module baud_tick_gen #(
  parameter int DIV_W        = 16,
  parameter int FRAC_W       = 4,
  parameter int OVERSAMPLE   = 16,
  parameter int DEF_DIV_INT  = 5,
  parameter int DEF_DIV_FRAC = 8
) (
  input  logic            clk,
  input  logic            rst,
  baud_tick_gen_if.slave  bus
);
  localparam int PC_W = DIV_W + 1;
  localparam int OC_W = $clog2(OVERSAMPLE);
  localparam logic [OC_W-1:0] OC_LAST = OC_W'(OVERSAMPLE - 1);
  localparam logic [OC_W-1:0] OC_HALF = OC_W'(OVERSAMPLE / 2);
  localparam logic [DIV_W-1:0] RST_INT = DIV_W'(DEF_DIV_INT);
  localparam logic [FRAC_W-1:0] RST_FRAC = FRAC_W'(DEF_DIV_FRAC);
  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   per_q, per_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [OC_W-1:0]   oc_q, oc_d;
  logic [DIV_W-1:0]  ai_q, ai_d;
  logic [FRAC_W-1:0] af_q, af_d;
  logic [DIV_W-1:0]  pi_q, pi_d;
  logic [FRAC_W-1:0] pf_q, pf_d;
  logic              pend_q, pend_d;
  logic              os_tick_q, os_tick_d;
  logic              bit_tick_q, bit_tick_d;
  logic              baud_q, baud_d;

  logic [DIV_W-1:0]  new_int;
  logic [FRAC_W:0]   acc_sum;
  logic              os_ev;
  logic              bit_ev;

  always_comb begin
    new_int = (bus.div_int == '0) ? DIV_W'(1) : bus.div_int;
    acc_sum = {1'b0, acc_q} + {1'b0, af_q};
    os_ev   = bus.en && (pc_q == per_q - PC_ONE);
    bit_ev  = os_ev && (oc_q == OC_LAST);

    pc_d       = pc_q;
    per_d      = per_q;
    acc_d      = acc_q;
    oc_d       = oc_q;
    ai_d       = ai_q;
    af_d       = af_q;
    pi_d       = pi_q;
    pf_d       = pf_q;
    pend_d     = pend_q;
    os_tick_d  = 1'b0;
    bit_tick_d = 1'b0;
    baud_d     = baud_q;

    if (bus.restart || (bus.load && !bus.en)) begin
      // Phase realignment: a fresh load wins, else a pending one lands now
      pc_d   = '0;
      oc_d   = '0;
      acc_d  = '0;
      baud_d = 1'b0;
      pend_d = 1'b0;
      if (bus.load) begin
        ai_d  = new_int;
        af_d  = bus.div_frac;
        per_d = {1'b0, new_int};
      end else if (pend_q) begin
        ai_d  = pi_q;
        af_d  = pf_q;
        per_d = {1'b0, pi_q};
      end else begin
        per_d = {1'b0, ai_q};
      end
    end else begin
      if (os_ev) begin
        pc_d       = '0;
        os_tick_d  = 1'b1;
        bit_tick_d = bit_ev;
        oc_d       = bit_ev ? '0 : oc_q + 1'b1;
        baud_d     = (oc_d >= OC_HALF);
        if (bit_ev && pend_q) begin
          ai_d   = pi_q;
          af_d   = pf_q;
          acc_d  = '0;
          per_d  = {1'b0, pi_q};
          pend_d = 1'b0;
        end else begin
          acc_d = acc_sum[FRAC_W-1:0];
          per_d = {1'b0, ai_q} + PC_W'(acc_sum[FRAC_W]);
        end
      end else if (bus.en) begin
        pc_d = pc_q + PC_ONE;
      end
      // Captured after the count so a boundary load re-arms pend
      if (bus.load) begin
        pi_d   = new_int;
        pf_d   = bus.div_frac;
        pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= '0;
      per_q      <= PC_W'(DEF_DIV_INT);
      acc_q      <= '0;
      oc_q       <= '0;
      ai_q       <= RST_INT;
      af_q       <= RST_FRAC;
      pi_q       <= RST_INT;
      pf_q       <= RST_FRAC;
      pend_q     <= 1'b0;
      os_tick_q  <= 1'b0;
      bit_tick_q <= 1'b0;
      baud_q     <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      per_q      <= per_d;
      acc_q      <= acc_d;
      oc_q       <= oc_d;
      ai_q       <= ai_d;
      af_q       <= af_d;
      pi_q       <= pi_d;
      pf_q       <= pf_d;
      pend_q     <= pend_d;
      os_tick_q  <= os_tick_d;
      bit_tick_q <= bit_tick_d;
      baud_q     <= baud_d;
    end
  end

  assign bus.os_tick  = os_tick_q;
  assign bus.bit_tick = bit_tick_q;
  assign bus.baud     = baud_q;
  assign bus.pend     = pend_q;
endmodule

// File: doc/baud_tick_gen.md
# baud_tick_gen

Parametrised, runtime-programmable baud-rate generator for the UART datapath. It replaces the fixed divide-by-88 square-wave generator. It produces an oversample tick for the RX sampler and a bit tick for the TX shifter, plus a baud square wave with the same low-then-high phase as the legacy output. The divisor is fractional, so arbitrary clock/baud ratios are reachable. Divisor updates are glitch-free, and an RX phase-restart input is provided.

## Interface
- DIV_W, 16, width of the integer divisor (clocks per oversample tick).
- FRAC_W, 4, width of the fractional divisor; fraction = div_frac / 2^FRAC_W.
- OVERSAMPLE, 16, oversample ticks per bit; even, >= 2.
- DEF_DIV_INT, 5, integer divisor after reset.
- DEF_DIV_FRAC, 8, fractional divisor after reset (5.5 x 16 = 88 clocks/bit).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  count enable; low freezes all counters.
- restart  in  1  one-cycle pulse; re-aligns bit phase to 0 (RX start-bit edge).
- load  in  1  one-cycle pulse; captures div_int/div_frac.
- div_int  in  DIV_W  new integer divisor; 0 is treated as 1.
- div_frac  in  FRAC_W  new fractional divisor.
- os_tick  out  1  one-cycle pulse per oversample period.
- bit_tick  out  1  one-cycle pulse per bit period, coincident with the wrapping os_tick.
- baud  out  1  bit-rate square wave: low for the first OVERSAMPLE/2 os periods of a bit, high for the rest.
- pend  out  1  a loaded divisor is waiting for the next bit boundary.

## Operation
- State:
  - prescaler pc (DIV_W+1)
  - current period per
  - fractional accumulator acc (FRAC_W)
  - oversample counter oc (0..OVERSAMPLE-1)
  - active divisor (ai, af)
  - pending divisor (pi, pf) with pend flag
- Reset: pc=0, oc=0, acc=0, ai=DEF_DIV_INT, af=DEF_DIV_FRAC, per=DEF_DIV_INT, os_tick=0, bit_tick=0, baud=0, pend=0.
- Enabled edge (en=1), pc != per-1: pc+1; os_tick=0, bit_tick=0.
- Enabled edge, pc == per-1 (os event):
  - pc=0, os_tick=1.
  - {c,acc} = acc + af; per = ai + c.
  - oc = (oc==OVERSAMPLE-1) ? 0 : oc+1.
  - bit_tick=1 iff oc wrapped.
  - baud = (new oc >= OVERSAMPLE/2).
- en=0: pc, oc, acc and baud hold; os_tick=bit_tick=0.
- Load with en=0: applied at that edge.
  - ai/af = inputs (0 -> 1).
  - pc=0, acc=0, oc=0, per=new ai, baud=0, pend=0.
- Load with en=1: captured into pi/pf, pend=1.
  - A second load while pend=1 overwrites pi/pf.
  - Applied on the edge that asserts bit_tick: ai/af <= pi/pf, acc=0, per=pi, pend=0. oc/baud wrap normally.
- restart=1 (any en):
  - pc=0, oc=0, acc=0, baud=0, os_tick=0, bit_tick=0.
  - per = pending pi if pend, else ai; a pending divisor is applied and pend=0.
- Priority: rst > restart > load > count. restart and load on the same edge: the load values are applied immediately, as the en=0 load case.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- With en held high from edge 1 after reset or restart, the first os_tick is high after edge ai.
- Fractional sequence: periods are ai, then ai + carry. With ai=5, af=8 (FRAC_W=4): 5,5,6,5,6,…
- Bit period: the first bit_tick after restart occurs at edge sum(first OVERSAMPLE periods), which is 87 for the defaults. Every following bit interval is exactly 88 clocks.
- div_int=1, div_frac=0: os_tick high every cycle while en=1.
- pend rises the edge after load (en=1). It falls on the edge bit_tick rises, or on restart/rst.
- rst asserted mid-bit: all outputs go to reset values immediately (asynchronous); a pending divisor is discarded.

## Test plan
- Defaults (5, 8, OVERSAMPLE=16), en=1 after reset:
  - os_tick gaps are 5,5,6,5,6…
  - first bit_tick at edge 87, then every 88 clocks.
  - baud low for 8 os ticks, then high for 8.
- Load div_int=10, div_frac=0 mid-bit, en=1:
  - pend=1 until the next bit_tick.
  - Following bits are 160 clocks with os_tick every 10 clocks.
- Load with en=0, then en=1: new divisor effective at once; first os_tick at edge div_int; pend never rises.
- restart asserted mid-bit: pc/oc cleared, baud=0, and the next bit_tick arrives 87 clocks later.
- restart and load on the same edge: the new divisor is used from that edge.
- en toggled low for 7 cycles mid-period, and rst pulsed mid-bit:
  - Toggle: os_tick timing stretched by exactly 7 clocks.
  - Reset: all outputs 0 asynchronously, default divisor restored, pend=0.
- div_int=0 load: behaves as div_int=1 (os_tick every cycle when div_frac=0).
